// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: handshake bundle between a pipeline stage register and its neighbours
//   in_valid/in_data     upstream payload offer
//   allow_in             register accepts a payload this cycle
//   ready_go             stage logic fed by out_data has finished
//   out_allow_in         downstream register accepts this cycle
//   out_valid/out_data   head payload offered downstream
//   flush                discard all held and arriving payloads
//   count                occupancy (0..2)
//   master drives the upstream/downstream side, slave is the register itself
interface pipe_skid_reg_if #(
   parameter int DATA_W = 64
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              allow_in;
   logic              ready_go;
   logic              out_allow_in;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              flush;
   logic [1:0]        count;
   modport master (
      output in_valid, in_data, ready_go, out_allow_in, flush,
      input  allow_in, out_valid, out_data, count
   );
   modport slave (
      input  in_valid, in_data, ready_go, out_allow_in, flush,
      output allow_in, out_valid, out_data, count
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: inter-stage pipeline register with ready_go stall, flush and optional skid entry
//   clk_i     rising-edge clock
//   reset_ni  synchronous active-low reset
//   stage     pipe_skid_reg_if slave: in_valid/in_data/allow_in upstream,
//             ready_go/out_allow_in/out_valid/out_data downstream, flush, count
//   DATA_W    payload width; SKID=1 adds a second entry so allow_in comes from a flop
module pipe_skid_reg #(
   parameter int DATA_W = 64,
   parameter int SKID   = 1
) (
   input logic            clk_i,
   input logic            reset_ni,
   pipe_skid_reg_if.slave stage
);
   logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic              accept, fire, main_upd;
   // With the skid entry, allow_in only looks at skid_valid_q, cutting the
   // combinational allow_in chain from downstream stages.
   assign stage.allow_in  = reset_ni && ((SKID != 0) ? !skid_valid_q
                          : (!main_valid_q || (stage.ready_go && stage.out_allow_in)));
   assign stage.out_valid = main_valid_q && stage.ready_go;
   assign stage.out_data  = main_data_q;
   assign stage.count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign accept          = stage.in_valid && stage.allow_in;
   assign fire            = stage.out_valid && stage.out_allow_in;
   assign main_upd        = !main_valid_q || fire;
   // Main refills from skid first to keep FIFO order; an accept that cannot
   // reach main lands in skid. Flush clears valids but leaves data untouched.
   always_comb begin
      main_valid_d = !stage.flush && (main_upd ? (skid_valid_q || accept) : main_valid_q);
      skid_valid_d = (SKID != 0) && !stage.flush
                   && (main_upd ? (skid_valid_q && accept) : (skid_valid_q || accept));
      main_data_d  = (stage.flush || !main_upd) ? main_data_q
                   : skid_valid_q ? skid_data_q
                   : accept ? stage.in_data : main_data_q;
      skid_data_d  = ((SKID != 0) && !stage.flush && accept && (!main_upd || skid_valid_q))
                   ? stage.in_data : skid_data_q;
   end
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and randomised checks of pipe_skid_reg with SKID=1 (u1) and SKID=0 (u0)
module tb_pipe_skid_reg;
   logic       clk = 1'b0;
   logic       rst_n;
   int         n_chk = 0, n_pass = 0;
   logic       iv1, rg1, oa1, fl1, ea1, ev1, iv0, rg0, oa0, fl0, ea0, ev0;
   logic [7:0] d1, d0;
   logic [7:0] q1[$], q0[$];
   pipe_skid_reg_if #(.DATA_W(8)) b1 ();
   pipe_skid_reg_if #(.DATA_W(8)) b0 ();
   pipe_skid_reg #(.DATA_W(8), .SKID(1)) u1 (.clk_i(clk), .reset_ni(rst_n), .stage(b1));
   pipe_skid_reg #(.DATA_W(8), .SKID(0)) u0 (.clk_i(clk), .reset_ni(rst_n), .stage(b0));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else n_pass++;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drv1(input logic iv, input logic [7:0] d, input logic rg, input logic oa, input logic fl);
      b1.in_valid = iv; b1.in_data = d; b1.ready_go = rg; b1.out_allow_in = oa; b1.flush = fl;
   endtask
   task automatic drv0(input logic iv, input logic [7:0] d, input logic rg, input logic oa, input logic fl);
      b0.in_valid = iv; b0.in_data = d; b0.ready_go = rg; b0.out_allow_in = oa; b0.flush = fl;
   endtask
   initial begin
      rst_n = 1'b0;
      drv1(0, 8'h00, 1, 1, 0);
      drv0(0, 8'h00, 1, 1, 0);
      tick(); tick();
      chk("rst_allow1", 32'(b1.allow_in), 0);
      chk("rst_allow0", 32'(b0.allow_in), 0);
      rst_n = 1'b1; #1;
      chk("rst_post_allow1", 32'(b1.allow_in), 1);
      chk("rst_post_ov1", 32'(b1.out_valid), 0);
      chk("rst_post_od1", 32'(b1.out_data), 0);
      chk("rst_post_cnt1", 32'(b1.count), 0);
      chk("rst_post_allow0", 32'(b0.allow_in), 1);
      // streaming, SKID=1
      drv1(1, 8'h01, 1, 1, 0); #1;
      chk("st_allow", 32'(b1.allow_in), 1);
      tick(); drv1(1, 8'h02, 1, 1, 0); #1;
      chk("st_ov1", 32'(b1.out_valid), 1);
      chk("st_od1", 32'(b1.out_data), 8'h01);
      chk("st_cnt1", 32'(b1.count), 1);
      tick(); drv1(1, 8'h03, 1, 1, 0); #1;
      chk("st_od2", 32'(b1.out_data), 8'h02);
      chk("st_cnt2", 32'(b1.count), 1);
      chk("st_allow2", 32'(b1.allow_in), 1);
      tick(); drv1(0, 8'h00, 1, 1, 0); #1;
      chk("st_od3", 32'(b1.out_data), 8'h03);
      chk("st_cnt3", 32'(b1.count), 1);
      tick(); #1;
      chk("st_empty", 32'(b1.count), 0);
      chk("st_empty_ov", 32'(b1.out_valid), 0);
      // backpressure, SKID=1
      drv1(1, 8'h0A, 1, 1, 0);
      tick(); drv1(1, 8'h0B, 1, 0, 0); #1;
      chk("bp_odA", 32'(b1.out_data), 8'h0A);
      chk("bp_allow1", 32'(b1.allow_in), 1);
      tick(); drv1(1, 8'h0C, 1, 0, 0); #1;
      chk("bp_allow0", 32'(b1.allow_in), 0);
      chk("bp_cnt2", 32'(b1.count), 2);
      chk("bp_holdA", 32'(b1.out_data), 8'h0A);
      tick(); #1;
      chk("bp_cnt2b", 32'(b1.count), 2);
      chk("bp_holdA2", 32'(b1.out_data), 8'h0A);
      drv1(1, 8'h0C, 1, 1, 0); #1;
      chk("bp_rel_allow", 32'(b1.allow_in), 0);
      tick(); #1;
      chk("bp_odB", 32'(b1.out_data), 8'h0B);
      chk("bp_cntB", 32'(b1.count), 1);
      chk("bp_allowB", 32'(b1.allow_in), 1);
      tick(); drv1(0, 8'h00, 1, 1, 0); #1;
      chk("bp_odC", 32'(b1.out_data), 8'h0C);
      chk("bp_cntC", 32'(b1.count), 1);
      tick(); #1;
      chk("bp_empty", 32'(b1.count), 0);
      // stage stall, SKID=0
      drv0(1, 8'h55, 1, 1, 0);
      tick(); drv0(0, 8'h00, 0, 1, 0); #1;
      chk("ss_ov", 32'(b0.out_valid), 0);
      chk("ss_allow", 32'(b0.allow_in), 0);
      chk("ss_od", 32'(b0.out_data), 8'h55);
      tick(); #1;
      chk("ss_cnt", 32'(b0.count), 1);
      chk("ss_hold", 32'(b0.out_data), 8'h55);
      drv0(0, 8'h00, 1, 1, 0); #1;
      chk("ss_go_ov", 32'(b0.out_valid), 1);
      chk("ss_go_allow", 32'(b0.allow_in), 1);
      tick(); #1;
      chk("ss_empty", 32'(b0.count), 0);
      // flush with both entries full, SKID=1
      drv1(1, 8'h11, 1, 0, 0);
      tick(); drv1(1, 8'h22, 1, 0, 0);
      tick(); drv1(1, 8'h77, 1, 0, 1); #1;
      chk("fl_cnt2", 32'(b1.count), 2);
      chk("fl_allow_full", 32'(b1.allow_in), 0);
      tick(); drv1(0, 8'h00, 1, 1, 0); #1;
      chk("fl_cnt0", 32'(b1.count), 0);
      chk("fl_ov0", 32'(b1.out_valid), 0);
      chk("fl_data_kept", 32'(b1.out_data), 8'h11);
      // flush together with a real accept of 0x77
      drv1(1, 8'h11, 1, 0, 0);
      tick(); drv1(1, 8'h77, 1, 0, 1); #1;
      chk("fl_acc_allow", 32'(b1.allow_in), 1);
      tick(); drv1(1, 8'h88, 1, 1, 0); #1;
      chk("fl_acc_cnt0", 32'(b1.count), 0);
      chk("fl_acc_ov0", 32'(b1.out_valid), 0);
      tick(); drv1(0, 8'h00, 1, 1, 0); #1;
      chk("fl_next_od", 32'(b1.out_data), 8'h88);
      chk("fl_next_cnt", 32'(b1.count), 1);
      tick(); #1;
      chk("fl_next_empty", 32'(b1.count), 0);
      // reset mid-stream
      drv1(1, 8'h99, 1, 0, 0);
      tick(); drv1(1, 8'h9A, 1, 0, 0);
      tick(); rst_n = 1'b0; drv1(0, 8'h00, 1, 1, 0); #1;
      chk("mr_allow_a", 32'(b1.allow_in), 0);
      tick(); tick();
      chk("mr_allow_b", 32'(b1.allow_in), 0);
      rst_n = 1'b1; #1;
      chk("mr_ov", 32'(b1.out_valid), 0);
      chk("mr_od", 32'(b1.out_data), 0);
      chk("mr_cnt", 32'(b1.count), 0);
      chk("mr_allow", 32'(b1.allow_in), 1);
      // randomised traffic against a queue model
      for (int i = 0; i < 10000; i++) begin
         iv1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom_range(0, 255));
         rg1 = ($urandom_range(0, 3) != 0); oa1 = ($urandom_range(0, 2) != 0);
         fl1 = ($urandom_range(0, 63) == 0);
         iv0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom_range(0, 255));
         rg0 = ($urandom_range(0, 3) != 0); oa0 = ($urandom_range(0, 2) != 0);
         fl0 = ($urandom_range(0, 63) == 0);
         drv1(iv1, d1, rg1, oa1, fl1);
         drv0(iv0, d0, rg0, oa0, fl0);
         #1;
         ea1 = q1.size() < 2;
         ev1 = q1.size() > 0 && rg1;
         ea0 = q0.size() == 0 || (rg0 && oa0);
         ev0 = q0.size() > 0 && rg0;
         chk("r1_cnt", 32'(b1.count), q1.size());
         chk("r1_allow", 32'(b1.allow_in), 32'(ea1));
         chk("r1_ov", 32'(b1.out_valid), 32'(ev1));
         if (ev1) chk("r1_od", 32'(b1.out_data), 32'(q1[0]));
         chk("r0_cnt", 32'(b0.count), q0.size());
         chk("r0_allow", 32'(b0.allow_in), 32'(ea0));
         chk("r0_ov", 32'(b0.out_valid), 32'(ev0));
         if (ev0) chk("r0_od", 32'(b0.out_data), 32'(q0[0]));
         b1.out_allow_in = !oa1; b1.ready_go = !rg1; #1;
         chk("r1_indep", 32'(b1.allow_in), 32'(ea1));
         b1.out_allow_in = oa1; b1.ready_go = rg1; #1;
         @(posedge clk);
         if (fl1) q1.delete();
         else begin
            if (ev1 && oa1) void'(q1.pop_front());
            if (iv1 && ea1) q1.push_back(d1);
         end
         if (fl0) q0.delete();
         else begin
            if (ev0 && oa0) void'(q0.pop_front());
            if (iv0 && ea0) q0.push_back(d0);
         end
         #1;
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
